// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for simple_cpu and instr_sequencer.
// Holds the instruction/data/address widths, where the 2-bit class field sits
// in an instruction, the class encodings and the default per-class hold counts.
package cpu_isa_pkg;

  localparam int unsigned INSTR_WIDTH = 20;
  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned ADDR_BITS   = 4;

  // Class field occupies the top CLASS_W bits of every instruction.
  localparam int unsigned CLASS_W   = 2;
  localparam int unsigned CLASS_MSB = INSTR_WIDTH - 1;

  typedef enum logic [CLASS_W-1:0] {
    ClsHalt  = 2'b00,
    ClsAlu   = 2'b01,
    ClsLoad  = 2'b10,
    ClsStore = 2'b11
  } cls_e;

  // Rising edges each class is held stable on the CPU instruction port.
  localparam int unsigned ALU_CYCLES_DEF   = 3;
  localparam int unsigned LOAD_CYCLES_DEF  = 4;
  localparam int unsigned STORE_CYCLES_DEF = 3;

endpackage

// File: rtl/instr_prog_mem.sv
// Program memory for instr_sequencer: synchronous write, asynchronous read.
// Contents are deliberately not reset so a loaded program survives rst.
// Ports:
//   clk_i    - write clock
//   we_i     - write enable (gated by the caller)
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - combinational read address
//   rdata_o  - combinational read data
module instr_prog_mem #(
  parameter int unsigned PC_BITS     = 5,
  parameter int unsigned INSTR_WIDTH = 20
) (
  input  logic                   clk_i,
  input  logic                   we_i,
  input  logic [PC_BITS-1:0]     waddr_i,
  input  logic [INSTR_WIDTH-1:0] wdata_i,
  input  logic [PC_BITS-1:0]     raddr_i,
  output logic [INSTR_WIDTH-1:0] rdata_o
);

  logic [INSTR_WIDTH-1:0] mem_q [2**PC_BITS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Self-sequencing instruction source for simple_cpu. The CPU has no handshake,
// so this block owns timing: each issued instruction is held on the port for a
// fixed number of rising edges chosen by its class, and a HALT-class word ends
// the run.
// Ports:
//   clk_i, rst_ni   - clock, asynchronous active-low reset
//   prog_we_i       - program write enable, ignored while busy_o
//   prog_addr_i     - program write address
//   prog_data_i     - program write data
//   start_i         - level-sampled run request (IDLE/HALTED only)
//   instruction_o   - registered instruction to the CPU (0 when not issuing)
//   instr_valid_o   - instruction_o carries an issued instruction
//   pc_o            - address of the instruction currently driven
//   busy_o          - run in progress
//   done_o          - a HALT was reached; held until next accepted start/reset
module instr_sequencer #(
  parameter int unsigned INSTR_WIDTH  = cpu_isa_pkg::INSTR_WIDTH,
  parameter int unsigned PC_BITS      = 5,
  parameter int unsigned ALU_CYCLES   = cpu_isa_pkg::ALU_CYCLES_DEF,
  parameter int unsigned LOAD_CYCLES  = cpu_isa_pkg::LOAD_CYCLES_DEF,
  parameter int unsigned STORE_CYCLES = cpu_isa_pkg::STORE_CYCLES_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   prog_we_i,
  input  logic [PC_BITS-1:0]     prog_addr_i,
  input  logic [INSTR_WIDTH-1:0] prog_data_i,
  input  logic                   start_i,
  output logic [INSTR_WIDTH-1:0] instruction_o,
  output logic                   instr_valid_o,
  output logic [PC_BITS-1:0]     pc_o,
  output logic                   busy_o,
  output logic                   done_o
);

  import cpu_isa_pkg::*;

  localparam int unsigned MaxAl   = (ALU_CYCLES > STORE_CYCLES) ? ALU_CYCLES : STORE_CYCLES;
  localparam int unsigned MaxHold = (LOAD_CYCLES > MaxAl) ? LOAD_CYCLES : MaxAl;
  // Counter only ever holds hold-1, so clog2(MaxHold) bits suffice.
  localparam int unsigned CntW    = (MaxHold > 1) ? $clog2(MaxHold) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StHalted} state_e;

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   valid_q, valid_d;
  logic [PC_BITS-1:0]     pc_q, pc_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [CntW-1:0]        cnt_q, cnt_d;

  logic [PC_BITS-1:0]     rd_addr;
  logic [INSTR_WIDTH-1:0] rd_data;
  cls_e                   fetch_cls;

  function automatic logic [CntW-1:0] hold_m1(cls_e cls);
    case (cls)
      ClsLoad:  return CntW'(LOAD_CYCLES - 1);
      ClsStore: return CntW'(STORE_CYCLES - 1);
      default:  return CntW'(ALU_CYCLES - 1);
    endcase
  endfunction

  instr_prog_mem #(
    .PC_BITS    (PC_BITS),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_prog_mem (
    .clk_i  (clk_i),
    .we_i   (prog_we_i && !busy_q),
    .waddr_i(prog_addr_i),
    .wdata_i(prog_data_i),
    .raddr_i(rd_addr),
    .rdata_o(rd_data)
  );

  // Start always fetches address 0; in RUN the lookahead is pc+1 (wraps).
  assign rd_addr   = (state_q == StRun) ? pc_q + PC_BITS'(1) : '0;
  assign fetch_cls = cls_e'(rd_data[INSTR_WIDTH-1 -: CLASS_W]);

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle, StHalted: begin
        if (start_i) begin
          pc_d = '0;
          if (fetch_cls != ClsHalt) begin
            instr_d = rd_data;
            valid_d = 1'b1;
            cnt_d   = hold_m1(fetch_cls);
            busy_d  = 1'b1;
            done_d  = 1'b0;
            state_d = StRun;
          end else begin
            instr_d = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StHalted;
          end
        end
      end
      StRun: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else if (fetch_cls != ClsHalt) begin
          // Back-to-back issue: next word replaces current with no bubble.
          pc_d    = rd_addr;
          instr_d = rd_data;
          cnt_d   = hold_m1(fetch_cls);
        end else begin
          pc_d    = rd_addr;
          instr_d = '0;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StHalted;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      instr_q <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instruction_o = instr_q;
  assign instr_valid_o = valid_q;
  assign pc_o          = pc_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: each run pushes the expected per-edge
// output trace derived from a bench copy of the program, then pops and
// compares one entry after every rising edge.
module tb_instr_sequencer;

  localparam int unsigned W  = 20;
  localparam int unsigned PB = 5;
  localparam int unsigned D  = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          prog_we_i;
  logic [PB-1:0] prog_addr_i;
  logic [W-1:0]  prog_data_i;
  logic          start_i;
  logic [W-1:0]  instruction_o;
  logic          instr_valid_o;
  logic [PB-1:0] pc_o;
  logic          busy_o;
  logic          done_o;

  typedef struct packed {
    logic [W-1:0]  instr;
    logic          valid;
    logic [PB-1:0] pc;
    logic          busy;
    logic          done;
  } exp_t;

  exp_t         sb_q[$];
  logic [W-1:0] model_mem [D];
  int           n_tests = 0;
  int           n_fail  = 0;

  instr_sequencer u_dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .prog_we_i    (prog_we_i),
    .prog_addr_i  (prog_addr_i),
    .prog_data_i  (prog_data_i),
    .start_i      (start_i),
    .instruction_o(instruction_o),
    .instr_valid_o(instr_valid_o),
    .pc_o         (pc_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int hold_of(input logic [W-1:0] ins);
    logic [1:0] cls;
    cls = ins[W-1 -: 2];
    return (cls == 2'b10) ? 4 : 3;
  endfunction

  function automatic exp_t mk_exp(input logic [W-1:0] ins, input logic v, input logic [PB-1:0] p,
                                  input logic b, input logic dn);
    exp_t e;
    e.instr = ins;
    e.valid = v;
    e.pc    = p;
    e.busy  = b;
    e.done  = dn;
    return e;
  endfunction

  // Expected trace from start: each word held hold_of() edges, HALT parks at its address.
  task automatic push_trace(input int n);
    int            pushed;
    logic [PB-1:0] p;
    logic [1:0]    cls;
    pushed = 0;
    p      = '0;
    while (pushed < n) begin
      cls = model_mem[p][W-1 -: 2];
      if (cls == 2'b00) begin
        sb_q.push_back(mk_exp('0, 1'b0, p, 1'b0, 1'b1));
        pushed++;
      end else begin
        for (int k = 0; k < hold_of(model_mem[p]) && pushed < n; k++) begin
          sb_q.push_back(mk_exp(model_mem[p], 1'b1, p, 1'b1, 1'b0));
          pushed++;
        end
        p = p + PB'(1);
      end
    end
  endtask

  task automatic load(input logic [PB-1:0] addr, input logic [W-1:0] data);
    prog_addr_i = addr;
    prog_data_i = data;
    prog_we_i   = 1'b1;
    @(posedge clk_i); #1;
    prog_we_i       = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".instr"}, 32'(instruction_o), 32'h0);
    check({tag, ".valid"}, 32'(instr_valid_o), 32'h0);
    check({tag, ".pc"},    32'(pc_o),          32'h0);
    check({tag, ".busy"},  32'(busy_o),        32'h0);
    check({tag, ".done"},  32'(done_o),        32'h0);
  endtask

  // Pulse start for one edge, then compare n edges; optionally try to overwrite
  // mem[1] with 0 on edges we_from..we_to (while the DUT should be busy).
  task automatic run(input string tag, input int n, input int we_from, input int we_to);
    exp_t e;
    push_trace(n);
    start_i = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(posedge clk_i); #1;
      start_i     = 1'b0;
      prog_we_i   = (c >= we_from && c <= we_to);
      prog_addr_i = PB'(1);
      prog_data_i = '0;
      if (sb_q.size() == 0) begin
        check($sformatf("%s.sb_empty c%0d", tag, c), 32'h1, 32'h0);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s.instr c%0d", tag, c), 32'(instruction_o), 32'(e.instr));
        check($sformatf("%s.valid c%0d", tag, c), 32'(instr_valid_o), 32'(e.valid));
        check($sformatf("%s.pc c%0d", tag, c),    32'(pc_o),          32'(e.pc));
        check($sformatf("%s.busy c%0d", tag, c),  32'(busy_o),        32'(e.busy));
        check($sformatf("%s.done c%0d", tag, c),  32'(done_o),        32'(e.done));
      end
    end
    prog_we_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni      = 1'b0;
    prog_we_i   = 1'b0;
    prog_addr_i = '0;
    prog_data_i = '0;
    start_i     = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_vals("reset");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // ALU run, with a write attempt to mem[1] while busy that must be dropped.
    load(5'd0, 20'b01000111000000000000);
    load(5'd1, 20'b01010011000000000000);
    load(5'd2, 20'b01110010000000000001);
    load(5'd3, 20'h00000);
    run("alu", 12, 2, 4);
    run("alu_rerun", 12, -1, -1);

    // LOAD_R held four edges.
    load(5'd0, 20'b10111000000011110000);
    load(5'd1, 20'h00000);
    run("load", 6, -1, -1);

    // Full ALU program: wraps 31 -> 0; ends on the 2nd hold edge of pc=1.
    for (int i = 0; i < 32; i++) load(PB'(i), 20'h40000 | W'(i));
    run("wrap", 101, -1, -1);

    // Asynchronous reset between clock edges.
    rst_ni = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    run("after_rst", 4, -1, -1);

    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // HALT at address 0, twice.
    load(5'd0, 20'h00000);
    run("halt0", 3, -1, -1);
    run("halt0_again", 3, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction-issue side of the simple CPU's 20-bit instruction port.
- Holds a small program memory that the bench or loader writes before a run.
- On start, drives one instruction at a time to simple_cpu, holding each stable for the fixed number of clock edges its instruction class needs.
- Replaces the hand-timed instruction stimulus with a self-sequencing source. The CPU has no handshake, so timing is owned here.

Parameters:
INSTR_WIDTH, 20, instruction width; must match simple_cpu.
PC_BITS, 5, program address width; depth = 2**PC_BITS = 32.
ALU_CYCLES, 3, rising edges each ALU instruction (class 01) is held; must be >= 1.
LOAD_CYCLES, 4, rising edges each LOAD_R instruction (class 10) is held; must be >= 1.
STORE_CYCLES, 3, rising edges each STORE_R instruction (class 11) is held; must be >= 1.

Ports:
clk  input  1  system clock, rising-edge.
rst  input  1  asynchronous, active-low reset (0 = reset).
prog_we  input  1  program write enable; honoured only when busy=0.
prog_addr  input  PC_BITS  program write address.
prog_data  input  INSTR_WIDTH  program write data.
start  input  1  level-sampled run request; honoured in IDLE and HALTED.
instruction  output  INSTR_WIDTH  instruction to simple_cpu; registered.
instr_valid  output  1  high while instruction holds a real issued instruction.
pc  output  PC_BITS  address of the instruction currently driven.
busy  output  1  high in RUN.
done  output  1  high in HALTED, after a HALT instruction is reached.

Behaviour:
- Class field: instruction[INSTR_WIDTH-1 -: 2]. Encodings: 00 = HALT, 01 = ALU, 10 = LOAD_R, 11 = STORE_R. Other bits are opaque to this block.
- Program memory:
  - 2**PC_BITS x INSTR_WIDTH array, asynchronous read, synchronous write.
  - Not cleared by reset; contents survive rst.
- Reset (rst=0, asynchronous): state=IDLE, instruction=0, instr_valid=0, pc=0, busy=0, done=0, hold counter=0.
- State IDLE / HALTED, start=1 at edge:
  - pc <= 0; fetch mem[0].
  - If the fetched class is not HALT: instruction <= mem[0], instr_valid <= 1, cnt <= hold(class)-1, busy <= 1, done <= 0, state <= RUN.
  - If the fetched class is HALT: state <= HALTED, done <= 1, instr_valid stays 0, instruction stays 0.
- State RUN, each edge:
  - cnt != 0: cnt <= cnt-1; instruction and pc unchanged.
  - cnt == 0: next = pc+1, wrapping mod 2**PC_BITS.
  - If mem[next] class != HALT: pc <= next, instruction <= mem[next], cnt <= hold-1. Back-to-back, no bubble.
  - If mem[next] class == HALT: instruction <= 0, instr_valid <= 0, busy <= 0, done <= 1, pc <= next, state <= HALTED.
- Latency and hold:
  - First instruction appears 1 edge after start is sampled.
  - Each instruction is held exactly hold(class) rising edges.
- Wrap-around: pc 31 -> 0 with no stall. A program with no HALT runs indefinitely.
- Simultaneous events and ignored inputs:
  - prog_we while busy=1 is ignored; memory is unchanged.
  - start while in RUN is ignored.
  - start and prog_we in the same IDLE edge: the write completes, and the run fetches the pre-write mem[0] if prog_addr=0. The bench must not rely on this case.
- Reset mid-run: outputs go to reset values immediately, without waiting for clk. The next start begins at pc 0.
- done stays at level 1 until the next accepted start or reset.

Decomposition:
- Shared package cpu_isa_pkg:
  - INSTR_WIDTH, DATA_WIDTH, ADDR_BITS.
  - CLASS_MSB and class width.
  - Class encodings CLS_HALT, CLS_ALU, CLS_LOAD, CLS_STORE.
  - Default hold counts.
  - Used by both simple_cpu and instr_sequencer.
- One sub-module, instr_prog_mem: write port plus asynchronous read array, parameterised by PC_BITS and INSTR_WIDTH.
- The FSM, hold counter and pc stay in instr_sequencer.

Test Plan:
1. ALU run:
   - Stimulus: load 20'b01000111000000000000, 20'b01010011000000000000, 20'b01110010000000000001 at 0..2 and HALT (0) at 3; pulse start.
   - Required: instr_valid=1 one edge later; each instruction held 3 edges with pc=0,1,2; then done=1, busy=0, instruction=0, pc=3.
2. LOAD_R hold:
   - Stimulus: mem[0]=20'b10111000000011110000, mem[1]=HALT; pulse start.
   - Required: instruction held 4 edges, then done=1.
3. Write blocked while busy:
   - Stimulus: during test-1 run, prog_we=1, prog_addr=1, prog_data=0.
   - Required: rerun still issues the original mem[1] ADD.
4. Wrap-around:
   - Stimulus: fill all 32 entries with ALU instructions; start.
   - Required: after 96 edges pc returns 0 with instruction=mem[0], no cycle with instr_valid=0, done stays 0.
5. Reset mid-run:
   - Stimulus: drop rst during the 2nd hold edge of pc=1.
   - Required: instruction=0, instr_valid=0, pc=0 asynchronously; a new start reissues mem[0] with memory intact.
6. Immediate HALT:
   - Stimulus: mem[0]=HALT; start.
   - Required: done=1 after 1 edge; instr_valid never asserts; a second start while HALTED repeats the same result.
